imem_boot_loader: RTL and testbench

Byte-stream boot loader sitting directly upstream of the single-cycle RISC-V core. Receives a framed program image one byte per handshake and writes it word-by-word into instruction memory through a dedicated write port. Holds the core in reset (`core_rst_n` low) until a complete image with a valid checksum has been loaded, then releases it.

---
 rtl/imem_boot_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a framed program image one byte per handshake and writes it
//   into instruction memory one 32-bit word at a time. The core is held in
//   reset until a complete image with a matching checksum has been loaded.
//
//   Frame: 0xA5, LEN_LO, LEN_HI, N*4 payload bytes (little-endian words),
//          CHK = XOR of all payload bytes.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_valid, rx_data      incoming byte stream
//   rx_ready               byte accepted when rx_valid & rx_ready at rising edge
//   reload                 one-cycle pulse, restarts loading from RUN or ERROR
//   imem_we/addr/wdata     instruction-memory write port (word address)
//   core_rst_n             core reset, released once the image is accepted
//   loaded                 image accepted, core running
//   error, err_code        load failure: 1 checksum, 2 length overflow, 3 timeout
//
// State        | meaning
// -------------+-----------------------------------------------------------
// S_WAIT_MAGIC | discard bytes until 0xA5
// S_LEN_LO     | expecting low byte of word count
// S_LEN_HI     | expecting high byte of word count, range check
// S_PAYLOAD    | assembling and writing payload words
// S_CHECK      | expecting checksum byte
// S_RUN        | image accepted, core out of reset, stream stalled
// S_ERROR      | load failed, bytes discarded until reload
module imem_boot_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              loaded,
    output logic              error,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_WAIT_MAGIC,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [7:0]  MAGIC     = 8'hA5;
    localparam logic [16:0] CAP_WORDS = 17'd1 << ADDR_W;
    localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT);

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  err_nxt;

    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_in;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_reg;
    logic [7:0]  chk;
    logic [15:0] tmr_cnt;

    logic        accept;
    logic        timed;
    logic        tmr_fire;
    logic        last_word;

    assign rx_ready   = (state != S_RUN);
    assign core_rst_n = (state == S_RUN);
    assign loaded     = (state == S_RUN);
    assign error      = (state == S_ERROR);

    assign accept    = rx_valid & rx_ready;
    assign timed     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_PAYLOAD) || (state == S_CHECK);
    assign len_in    = {rx_data, len_lo};
    assign last_word = (word_idx == (len - 16'd1));

    // Idle timer: down-counter reloaded on every accepted byte and whenever
    // outside the in-frame states; fires on the TIMEOUT-th idle edge.
    assign tmr_fire = (TIMEOUT != 0) && timed && !accept && (tmr_cnt == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_cnt <= TMO_LOAD;
        end else if (!timed || accept) begin
            tmr_cnt <= TMO_LOAD;
        end else if (tmr_cnt != 16'd0) begin
            tmr_cnt <= tmr_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT_MAGIC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 2'd0;
        case (state)
            S_WAIT_MAGIC: begin
                if (accept && (rx_data == MAGIC)) begin
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len_in} > CAP_WORDS) begin
                        state_nxt = S_ERROR;
                        err_nxt   = ERR_LEN;
                    end else if (len_in == 16'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept && (byte_idx == 2'd3) && last_word) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (rx_data == chk) begin
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_ERROR;
                        err_nxt   = ERR_CHK;
                    end
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_nxt = S_WAIT_MAGIC;
                end
            end
            S_ERROR: begin
                if (reload) begin
                    state_nxt = S_WAIT_MAGIC;
                end
            end
            default: begin
                state_nxt = S_WAIT_MAGIC;
            end
        endcase

        if (tmr_fire) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_TMO;
        end
    end

    // Error code is latched on entry to ERROR and held; leaving ERROR clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_code <= 2'd0;
        end else if (state_nxt == S_ERROR) begin
            if (state != S_ERROR) begin
                err_code <= err_nxt;
            end
        end else begin
            err_code <= 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo     <= 8'd0;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            byte_idx   <= 2'd0;
            asm_reg    <= 24'd0;
            chk        <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_WAIT_MAGIC: begin
                        if (rx_data == MAGIC) begin
                            word_idx <= 16'd0;
                            byte_idx <= 2'd0;
                            chk      <= 8'd0;
                        end
                    end
                    S_LEN_LO: begin
                        len_lo <= rx_data;
                    end
                    S_LEN_HI: begin
                        len <= len_in;
                    end
                    S_PAYLOAD: begin
                        chk      <= chk ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        // First byte ends up in [7:0] once three have shifted in.
                        asm_reg  <= {rx_data, asm_reg[23:8]};
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            imem_wdata <= {rx_data, asm_reg};
                            word_idx   <= word_idx + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 10;
    localparam int CAP     = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              loaded;
    logic              error;
    logic [1:0]        err_code;

    imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .loaded     (loaded),
        .error      (error),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed writes, captured mid-cycle.
    int unsigned wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    // Reference expectations for randomized frames.
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_run;
    logic [1:0]  exp_code;

    typedef struct {
        logic [191:0] b;
        int           n;
        int           nwr;
        logic [31:0]  w_first;
        logic [31:0]  w_last;
        int           a_last;
        logic         exp_run;
        logic [1:0]   exp_code;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reload   = 1'b0;
        rst_n    = 1'b0;
        #3;
        step();
        rst_n = 1'b1;
        step();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_ready"},   32'(rx_ready),   32'd1);
        check({tag, " imem_we"},    32'(imem_we),    32'd0);
        check({tag, " imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, " imem_wdata"}, imem_wdata,      32'd0);
        check({tag, " core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({tag, " loaded"},     32'(loaded),     32'd0);
        check({tag, " error"},      32'(error),      32'd0);
        check({tag, " err_code"},   32'(err_code),   32'd0);
    endtask

    task automatic send_two_word(input logic [7:0] chk_byte);
        logic [7:0] fr[12];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h81, 8'h10, 8'h00, 8'h41};
        fr[11] = chk_byte;
        for (int i = 0; i < 12; i++) send_byte(fr[i]);
    endtask

    // Frame-level interpretation of a byte stream: find the magic, read the
    // count, slice the payload into words and compare the XOR.
    function automatic void model(input logic [7:0] s[$]);
        int          i;
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_run  = 1'b0;
        exp_code = 2'd0;
        i = 0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i + 2 >= s.size()) return;
        n = int'(s[i+1]) + 256 * int'(s[i+2]);
        i += 3;
        if (n > CAP) begin
            exp_code = 2'd2;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            w = {s[i+4*k+3], s[i+4*k+2], s[i+4*k+1], s[i+4*k]};
            exp_addr.push_back(k);
            exp_data.push_back(w);
            x = x ^ s[i+4*k] ^ s[i+4*k+1] ^ s[i+4*k+2] ^ s[i+4*k+3];
        end
        if (s[i+4*n] == x) exp_run = 1'b1;
        else               exp_code = 2'd1;
    endfunction

    initial begin
        logic [7:0] s[$];
        logic [7:0] b;
        logic [7:0] x;
        int         n;
        int         ng;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;

        vt[0] = '{b: 192'({8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                           8'h13, 8'h81, 8'h10, 8'h00, 8'h41}),
                  n: 12, nwr: 2, w_first: 32'h00500093, w_last: 32'h00108113,
                  a_last: 1, exp_run: 1'b1, exp_code: 2'd0};
        vt[1] = '{b: 192'({8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00}),
                  n: 6, nwr: 0, w_first: 32'h0, w_last: 32'h0,
                  a_last: 0, exp_run: 1'b1, exp_code: 2'd0};
        vt[2] = '{b: 192'({8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                           8'h13, 8'h81, 8'h10, 8'h00, 8'h40}),
                  n: 12, nwr: 2, w_first: 32'h00500093, w_last: 32'h00108113,
                  a_last: 1, exp_run: 1'b0, exp_code: 2'd1};
        vt[3] = '{b: 192'({8'hA5, 8'h05, 8'h00, 8'h11, 8'h22}),
                  n: 5, nwr: 0, w_first: 32'h0, w_last: 32'h0,
                  a_last: 0, exp_run: 1'b0, exp_code: 2'd2};
        vt[4] = '{b: 192'({8'hA5, 8'h04, 8'h00,
                           128'h0102030405060708090A0B0C0D0E0F10, 8'h10}),
                  n: 20, nwr: 4, w_first: 32'h04030201, w_last: 32'h100F0E0D,
                  a_last: 3, exp_run: 1'b1, exp_code: 2'd0};
        vt[5] = '{b: 192'({8'h12, 8'h34}),
                  n: 2, nwr: 0, w_first: 32'h0, w_last: 32'h0,
                  a_last: 0, exp_run: 1'b0, exp_code: 2'd0};

        do_reset();
        check_reset_outputs("reset");

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < vt[i].n; j++) send_byte(vt[i].b[8*(vt[i].n-1-j) +: 8]);
            idle(2);
            check($sformatf("vec%0d nwr", i), wr_data.size(), vt[i].nwr);
            if (vt[i].nwr > 0 && wr_data.size() == vt[i].nwr) begin
                check($sformatf("vec%0d addr0", i), wr_addr[0], 32'd0);
                check($sformatf("vec%0d data0", i), wr_data[0], vt[i].w_first);
                check($sformatf("vec%0d addrN", i), wr_addr[vt[i].nwr-1], vt[i].a_last);
                check($sformatf("vec%0d dataN", i), wr_data[vt[i].nwr-1], vt[i].w_last);
            end
            check($sformatf("vec%0d loaded", i),     32'(loaded),     32'(vt[i].exp_run));
            check($sformatf("vec%0d core_rst_n", i), 32'(core_rst_n), 32'(vt[i].exp_run));
            check($sformatf("vec%0d rx_ready", i),   32'(rx_ready),   32'(!vt[i].exp_run));
            check($sformatf("vec%0d error", i),      32'(error),      32'(vt[i].exp_code != 2'd0));
            check($sformatf("vec%0d err_code", i),   32'(err_code),   32'(vt[i].exp_code));
        end

        // Write strobe timing, release timing, reload in RUN.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
        check("strobe early", 32'(imem_we), 32'd0);
        send_byte(8'h00);
        check("strobe on", 32'(imem_we), 32'd1);
        check("strobe addr", 32'(imem_addr), 32'd0);
        check("strobe data", imem_wdata, 32'h00500093);
        check("core held pre-chk", 32'(core_rst_n), 32'd0);
        send_byte(8'hC3);
        check("strobe off", 32'(imem_we), 32'd0);
        check("release core_rst_n", 32'(core_rst_n), 32'd1);
        check("release loaded", 32'(loaded), 32'd1);
        check("release rx_ready", 32'(rx_ready), 32'd0);
        idle(3);
        check("run stays", 32'(loaded), 32'd1);
        pulse_reload();
        check("reload core_rst_n", 32'(core_rst_n), 32'd0);
        check("reload loaded", 32'(loaded), 32'd0);
        check("reload rx_ready", 32'(rx_ready), 32'd1);

        // Empty image with rx_valid toggling.
        do_reset();
        send_byte(8'h00); idle(1); send_byte(8'hFF); idle(1);
        send_byte(8'hA5); idle(1); send_byte(8'h00); idle(1);
        send_byte(8'h00); idle(1); send_byte(8'h00); idle(1);
        check("toggle loaded", 32'(loaded), 32'd1);
        check("toggle nwr", wr_data.size(), 32'd0);

        // Bad checksum, reload, good frame.
        do_reset();
        send_two_word(8'h40);
        idle(1);
        check("badchk error", 32'(error), 32'd1);
        check("badchk code", 32'(err_code), 32'd1);
        check("badchk nwr", wr_data.size(), 32'd2);
        send_byte(8'hA5);
        check("error holds", 32'(err_code), 32'd1);
        pulse_reload();
        check("reload clr error", 32'(error), 32'd0);
        check("reload clr code", 32'(err_code), 32'd0);
        send_two_word(8'h41);
        check("reload good loaded", 32'(loaded), 32'd1);
        check("reload good nwr", wr_data.size(), 32'd4);

        // Timeout boundary.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h93);
        idle(TIMEOUT - 1);
        check("tmo early", 32'(error), 32'd0);
        idle(1);
        check("tmo error", 32'(error), 32'd1);
        check("tmo code", 32'(err_code), 32'd3);
        idle(2);
        check("tmo nwr", wr_data.size(), 32'd0);

        // Reset while the 4th payload byte is presented: no write.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        #2;
        rst_n = 1'b0;
        step();
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        idle(2);
        check("rst4 nwr", wr_data.size(), 32'd0);
        check_reset_outputs("rst4");

        // In-flight strobe dropped asynchronously.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        check("async we drop", 32'(imem_we), 32'd0);
        check("async wdata", imem_wdata, 32'd0);
        step();
        check("async nwr", wr_data.size(), 32'd0);
        rst_n = 1'b1;

        // Async reset out of RUN.
        do_reset();
        send_two_word(8'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async run");
        step();
        rst_n = 1'b1;

        // Randomized frames against the frame-level model.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            s.delete();
            ng = $urandom_range(0, 2);
            for (int k = 0; k < ng; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                s.push_back(b);
            end
            s.push_back(8'hA5);
            n = $urandom_range(0, CAP + 2);
            if ($urandom_range(0, 9) == 0) n = 256 + $urandom_range(0, 3);
            s.push_back(8'(n % 256));
            s.push_back(8'(n / 256));
            if (n <= CAP) begin
                x = 8'h00;
                for (int k = 0; k < 4 * n; k++) begin
                    b = 8'($urandom_range(0, 255));
                    x = x ^ b;
                    s.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                s.push_back(x);
            end else begin
                s.push_back(8'($urandom_range(0, 255)));
                s.push_back(8'($urandom_range(0, 255)));
            end
            model(s);
            foreach (s[k]) begin
                send_byte(s[k]);
                idle($urandom_range(0, 3));
            end
            idle(1);
            check($sformatf("rnd%0d nwr", t), wr_data.size(), exp_data.size());
            for (int k = 0; k < exp_data.size() && k < wr_data.size(); k++) begin
                check($sformatf("rnd%0d addr%0d", t, k), wr_addr[k], exp_addr[k]);
                check($sformatf("rnd%0d data%0d", t, k), wr_data[k], exp_data[k]);
            end
            check($sformatf("rnd%0d loaded", t),     32'(loaded),     32'(exp_run));
            check($sformatf("rnd%0d core_rst_n", t), 32'(core_rst_n), 32'(exp_run));
            check($sformatf("rnd%0d error", t),      32'(error),      32'(exp_code != 2'd0));
            check($sformatf("rnd%0d err_code", t),   32'(err_code),   32'(exp_code));
            pulse_reload();
            check($sformatf("rnd%0d idle after reload", t), 32'({loaded, error, rx_ready}), 32'b001);
            wr_addr.delete();
            wr_data.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
